// File: rtl/multicycle_datapath_pkg.sv
// Shared definitions for the multicycle RV32I datapath: phase encoding and the
// control codes the external main decoder drives into the datapath.
package multicycle_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_WB
   } phase_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MDR = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_datapath_regfile.sv
// Register file with two combinational read ports and one write port.
// x0 and indices at or above REG_COUNT read as zero and ignore writes.
module regfile_param #(
   parameter int XLEN      = 32,
   parameter int REG_COUNT = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [4:0]      ra1,
   input  logic [4:0]      ra2,
   input  logic [4:0]      wa,
   input  logic            we,
   input  logic [XLEN-1:0] wd,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);

   localparam int AW = $clog2(REG_COUNT);

   logic [XLEN-1:0] regs [REG_COUNT];

   function automatic logic valid_idx(input logic [4:0] idx);
      return (idx != 5'd0) && (int'(idx) < REG_COUNT);
   endfunction

   assign rd1 = valid_idx(ra1) ? regs[ra1[AW-1:0]] : '0;
   assign rd2 = valid_idx(ra2) ? regs[ra2[AW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (we && valid_idx(wa)) begin
         regs[wa[AW-1:0]] <= wd;
      end
   end

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle RV32I datapath sharing one memory port between fetch and data access.
// Optional performance counters are enabled with MULTICYCLE_PERF_CNT_EN.
module multicycle_datapath
   import multicycle_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter int              REG_COUNT = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [1:0]      result_src,
   input  logic [1:0]      imm_src,
   input  logic            alu_src,
   input  logic [2:0]      alu_control,
   input  logic            reg_write,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic            pc_src,
   input  logic            mem_ready,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [31:0]     instr,
   output logic            zero,
   output logic [XLEN-1:0] pc
`ifdef MULTICYCLE_PERF_CNT_EN
   ,
   output logic [63:0]     cycle_cnt,
   output logic [63:0]     instret_cnt
`endif
);

   phase_t          state;
   logic [31:0]     ir;
   logic [XLEN-1:0] oldpc, a_reg, b_reg, aluout, mdr;
   logic [XLEN-1:0] imm, srcb, alu_result, wb_data, rd1, rd2;

   regfile_param #(.XLEN(XLEN), .REG_COUNT(REG_COUNT)) u_rf (
      .clk   (clk),
      .reset (reset),
      .ra1   (ir[19:15]),
      .ra2   (ir[24:20]),
      .wa    (ir[11:7]),
      .we    (reg_write && (state == S_WB) && !reset),
      .wd    (wb_data),
      .rd1   (rd1),
      .rd2   (rd2)
   );

   always_comb begin
      imm = '0;
      case (imm_src)
         IMM_I: imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
         IMM_S: imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
         IMM_B: imm = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         IMM_J: imm = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

   assign srcb = alu_src ? imm : b_reg;

   always_comb begin
      alu_result = '0;
      case (alu_control)
         ALU_ADD: alu_result = a_reg + srcb;
         ALU_SUB: alu_result = a_reg - srcb;
         ALU_AND: alu_result = a_reg & srcb;
         ALU_OR:  alu_result = a_reg | srcb;
         ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(a_reg) < $signed(srcb))};
         default: alu_result = '0;
      endcase
   end

   always_comb begin
      wb_data = '0;
      case (result_src)
         RES_ALU: wb_data = aluout;
         RES_MDR: wb_data = mdr;
         RES_PC4: wb_data = oldpc + XLEN'(4);
         default: wb_data = '0;
      endcase
   end

   // Reset gates the request combinationally so an aborted access drops at once.
   assign zero      = reset | (alu_result == '0);
   assign mem_req   = !reset && ((state == S_FETCH) || (state == S_MEM));
   assign mem_we    = !reset && (state == S_MEM) && mem_write;
   assign mem_addr  = (state == S_MEM) ? aluout : pc;
   assign mem_wdata = b_reg;
   assign instr     = ir;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_FETCH;
         pc     <= RESET_PC;
         ir     <= '0;
         oldpc  <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         aluout <= '0;
         mdr    <= '0;
      end else begin
         case (state)
            S_FETCH: if (mem_ready) begin
               ir    <= mem_rdata[31:0];
               oldpc <= pc;
               pc    <= pc + XLEN'(4);
               state <= S_DECODE;
            end
            S_DECODE: begin
               a_reg <= rd1;
               b_reg <= rd2;
               state <= S_EXECUTE;
            end
            S_EXECUTE: begin
               aluout <= alu_result;
               if (pc_src) pc <= oldpc + imm;
               if (mem_read || mem_write) state <= S_MEM;
               else if (reg_write)        state <= S_WB;
               else                       state <= S_FETCH;
            end
            S_MEM: if (mem_ready) begin
               if (mem_write) begin
                  state <= S_FETCH;
               end else begin
                  mdr   <= mem_rdata;
                  state <= S_WB;
               end
            end
            S_WB:    state <= S_FETCH;
            default: state <= S_FETCH;
         endcase
      end
   end

`ifdef MULTICYCLE_PERF_CNT_EN
   // An instruction retires whenever the sequencer heads back to FETCH.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if ((state == S_WB) ||
             ((state == S_MEM) && mem_ready && mem_write) ||
             ((state == S_EXECUTE) && !(mem_read || mem_write) && !reg_write))
            instret_cnt <= instret_cnt + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath (RV32E register count, RESET_PC 0x100);
// the bench plays both the main decoder and the memory.
module tb_multicycle_datapath;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  result_src, imm_src;
   logic        alu_src;
   logic [2:0]  alu_control;
   logic        reg_write, mem_read, mem_write, pc_src;
   logic        branch, jump;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_req, mem_we, zero;
   logic [31:0] mem_addr, mem_wdata, instr, pc;

   int errors = 0;
   int checks = 0;

   multicycle_datapath #(.XLEN(32), .REG_COUNT(16), .RESET_PC(32'h100)) dut (
      .clk         (clk),
      .reset       (reset),
      .result_src  (result_src),
      .imm_src     (imm_src),
      .alu_src     (alu_src),
      .alu_control (alu_control),
      .reg_write   (reg_write),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .pc_src      (pc_src),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .instr       (instr),
      .zero        (zero),
      .pc          (pc)
   );

   always #5 clk = ~clk;

   // Decoder model: branches are taken only when the ALU compare reports zero.
   assign pc_src = jump | (branch & zero);

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [31:0] word, input logic [1:0] rsrc,
                                input logic [1:0] isrc, input logic asrc,
                                input logic [2:0] aop, input logic rw, input logic mr,
                                input logic mw, input logic br, input logic jp);
      mem_rdata   = word;
      mem_ready   = 1'b1;
      result_src  = rsrc;
      imm_src     = isrc;
      alu_src     = asrc;
      alu_control = aop;
      reg_write   = rw;
      mem_read    = mr;
      mem_write   = mw;
      branch      = br;
      jump        = jp;
   endtask

   // Runs a store with mem_ready tied high and checks the data access it issues.
   task automatic storeCheck(input logic [31:0] word, input string tag,
                             input logic [31:0] exp_addr, input logic [31:0] exp_data);
      applyStimulus(word, 2'b00, 2'b01, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(3);
      checkOutput({tag, "_we"},    {31'd0, mem_we},   32'd1);
      checkOutput({tag, "_addr"},  mem_addr,          exp_addr);
      checkOutput({tag, "_wdata"}, mem_wdata,         exp_data);
      step(1);
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(32'h0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      mem_ready = 1'b0;
      step(1);
      checkOutput("reset_pc",      pc,                32'h100);
      checkOutput("reset_req",     {31'd0, mem_req},  32'd0);
      checkOutput("reset_we",      {31'd0, mem_we},   32'd0);
      checkOutput("reset_zero",    {31'd0, zero},     32'd1);
      checkOutput("reset_instr",   instr,             32'd0);
      reset = 1'b0;
      #1;
      checkOutput("first_req",     {31'd0, mem_req},  32'd1);
      checkOutput("first_addr",    mem_addr,          32'h100);

      // addi x1,x0,5 ; add x2,x1,x1
      applyStimulus(32'h00500093, 2'b00, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(4);
      checkOutput("addi_pc",       pc,                32'h104);
      applyStimulus(32'h00108133, 2'b00, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(4);
      checkOutput("add_pc",        pc,                32'h108);

      // beq x0,x0,-8 at 0x108: taken, back to 0x100
      applyStimulus(32'hFE000CE3, 2'b00, 2'b10, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(2);
      checkOutput("beq_zero",      {31'd0, zero},     32'd1);
      step(1);
      checkOutput("beq_taken_pc",  pc,                32'h100);
      checkOutput("beq_fetch_addr", mem_addr,         32'h100);

      // sw x2,4(x0) with three wait cycles in MEM
      applyStimulus(32'h00202223, 2'b00, 2'b01, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(3);
      mem_ready = 1'b0;
      checkOutput("sw_req",        {31'd0, mem_req},  32'd1);
      checkOutput("sw_we",         {31'd0, mem_we},   32'd1);
      checkOutput("sw_addr",       mem_addr,          32'h4);
      checkOutput("sw_wdata",      mem_wdata,         32'd10);
      for (int i = 0; i < 2; i++) begin
         step(1);
         checkOutput("sw_hold_addr",  mem_addr,       32'h4);
         checkOutput("sw_hold_wdata", mem_wdata,      32'd10);
         checkOutput("sw_hold_we",    {31'd0, mem_we}, 32'd1);
      end
      step(1);
      checkOutput("sw_wait_req",   {31'd0, mem_req},  32'd1);
      checkOutput("sw_wait_we",    {31'd0, mem_we},   32'd1);
      mem_ready = 1'b1;
      step(1);
      checkOutput("sw_done_we",    {31'd0, mem_we},   32'd0);
      checkOutput("sw_done_pc",    pc,                32'h104);

      // beq x1,x0,8 at 0x104: untaken since x1=5
      applyStimulus(32'h00008463, 2'b00, 2'b10, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(2);
      checkOutput("bne_zero",      {31'd0, zero},     32'd0);
      step(1);
      checkOutput("beq_untaken_pc", pc,               32'h108);

      // addi x0,x0,7 ; addi x20,x0,9 (index beyond REG_COUNT)
      applyStimulus(32'h00700013, 2'b00, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(4);
      checkOutput("addi_x0_pc",    pc,                32'h10C);
      applyStimulus(32'h00900A13, 2'b00, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(4);
      checkOutput("addi_x20_pc",   pc,                32'h110);

      // jal x1,8 at 0x110: x1 = 0x114, pc = 0x118
      applyStimulus(32'h008000EF, 2'b10, 2'b11, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(4);
      checkOutput("jal_pc",        pc,                32'h118);

      storeCheck(32'h00002623, "sw_x0",  32'hC, 32'd0);
      storeCheck(32'h01402423, "sw_x20", 32'h8, 32'd0);
      storeCheck(32'h00102023, "sw_x1",  32'h0, 32'h114);
      checkOutput("stores_pc",     pc,                32'h124);

      // lw x3,4(x0) returning 0xCAFE0001, then store it back out
      applyStimulus(32'h00402183, 2'b01, 2'b00, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(3);
      mem_rdata = 32'hCAFE0001;
      checkOutput("lw_req",        {31'd0, mem_req},  32'd1);
      checkOutput("lw_we",         {31'd0, mem_we},   32'd0);
      checkOutput("lw_addr",       mem_addr,          32'h4);
      step(2);
      checkOutput("lw_pc",         pc,                32'h128);
      storeCheck(32'h00302823, "sw_x3", 32'h10, 32'hCAFE0001);

      // lw x4,4(x0) aborted by reset while waiting in MEM
      applyStimulus(32'h00402203, 2'b01, 2'b00, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(3);
      mem_ready = 1'b0;
      step(1);
      checkOutput("lw_wait_req",   {31'd0, mem_req},  32'd1);
      reset = 1'b1;
      #1;
      checkOutput("abort_req",     {31'd0, mem_req},  32'd0);
      checkOutput("abort_zero",    {31'd0, zero},     32'd1);
      step(1);
      checkOutput("abort_pc",      pc,                32'h100);
      reset = 1'b0;
      storeCheck(32'h00402023, "sw_x4_after_abort", 32'h0, 32'd0);
      storeCheck(32'h00102023, "sw_x1_after_reset", 32'h0, 32'd0);
      checkOutput("final_pc",      pc,                32'h108);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
